// File: rtl/hc_buffer_responder.sv
// Host-visible buffer responder: read/write access to NUM_BUFFERS x MEM_DEPTH cache lines,
// with fixed-latency reads, an ordered response queue and credit-based read flow control.
module hc_buffer_responder #(
  parameter int unsigned NUM_BUFFERS  = 4,
  parameter int unsigned MEM_DEPTH    = 64,
  parameter int unsigned DATA_WIDTH   = 512,
  parameter int unsigned OFFSET_WIDTH = 16,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned RSP_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rd_req_valid,
  output logic                    rd_req_ready,
  input  logic [7:0]              rd_req_buffer,
  input  logic [OFFSET_WIDTH-1:0] rd_req_offset,
  output logic                    rd_rsp_valid,
  input  logic                    rd_rsp_ready,
  output logic [DATA_WIDTH-1:0]   rd_rsp_data,
  output logic                    rd_rsp_err,
  input  logic                    wr_req_valid,
  output logic                    wr_req_ready,
  input  logic [7:0]              wr_req_buffer,
  input  logic [OFFSET_WIDTH-1:0] wr_req_offset,
  input  logic [DATA_WIDTH-1:0]   wr_req_data,
  output logic                    wr_rsp_valid,
  output logic                    wr_rsp_err,
  output logic                    idle,
  output logic [31:0]             rd_count,
  output logic [31:0]             wr_count
);

  localparam int unsigned WORDS  = NUM_BUFFERS * MEM_DEPTH;
  localparam int unsigned ADDR_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CNT_W  = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned LAST   = READ_LATENCY - 1;

  function automatic logic out_of_range(input logic [7:0] b, input logic [OFFSET_WIDTH-1:0] o);
    return (32'(b) >= NUM_BUFFERS) || (32'(o) >= MEM_DEPTH);
  endfunction

  function automatic logic [ADDR_W-1:0] word_addr(input logic [7:0] b,
                                                  input logic [OFFSET_WIDTH-1:0] o);
    return ADDR_W'(32'(b) * MEM_DEPTH + 32'(o));
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == RSP_DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshakes: a request or response transfers on a rising edge where valid and ready
  // are both high; valid never depends on ready, and ready depends only on registered state.
  logic                  rd_accept, wr_accept, rd_oor, wr_oor, rsp_pop;
  logic [ADDR_W-1:0]     rd_addr, wr_addr;

  logic [DATA_WIDTH-1:0] mem_q [WORDS];

  logic                  pipe_vld_q  [READ_LATENCY];
  logic                  pipe_err_q  [READ_LATENCY];
  logic [DATA_WIDTH-1:0] pipe_data_q [READ_LATENCY];

  logic [DATA_WIDTH-1:0] fifo_data_q [RSP_DEPTH];
  logic                  fifo_err_q  [RSP_DEPTH];
  logic [PTR_W-1:0]      fifo_rd_ptr_q, fifo_wr_ptr_q;
  logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic                  fifo_empty, fifo_push, fifo_pop;

  logic [CNT_W-1:0]      credit_q, credit_d;
  logic                  wr_rsp_valid_q, wr_rsp_err_q;
  logic [31:0]           rd_count_q, wr_count_q;

  assign rd_oor    = out_of_range(rd_req_buffer, rd_req_offset);
  assign wr_oor    = out_of_range(wr_req_buffer, wr_req_offset);
  assign rd_addr   = word_addr(rd_req_buffer, rd_req_offset);
  assign wr_addr   = word_addr(wr_req_buffer, wr_req_offset);
  assign rd_accept = rd_req_valid && rd_req_ready;
  assign wr_accept = wr_req_valid;

  // Storage is never reset; the read below samples pre-write contents (read-first).
  always_ff @(posedge clk) begin
    if (wr_accept && !wr_oor) mem_q[wr_addr] <= wr_req_data;
  end

  always_ff @(posedge clk) begin
    pipe_data_q[0] <= rd_oor ? '0 : mem_q[rd_addr];
    pipe_err_q[0]  <= rd_oor;
    for (int i = 1; i < int'(READ_LATENCY); i++) begin
      pipe_data_q[i] <= pipe_data_q[i-1];
      pipe_err_q[i]  <= pipe_err_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(READ_LATENCY); i++) pipe_vld_q[i] <= 1'b0;
    end else begin
      pipe_vld_q[0] <= rd_accept;
      for (int i = 1; i < int'(READ_LATENCY); i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
    end
  end

  // The pipe output bypasses the queue only when the queue is empty and the consumer is ready.
  assign fifo_empty   = (fifo_cnt_q == '0);
  assign rd_rsp_valid = !fifo_empty || pipe_vld_q[LAST];
  assign rd_rsp_data  = !fifo_empty ? fifo_data_q[fifo_rd_ptr_q] :
                        (pipe_vld_q[LAST] ? pipe_data_q[LAST] : '0);
  assign rd_rsp_err   = !fifo_empty ? fifo_err_q[fifo_rd_ptr_q] :
                        (pipe_vld_q[LAST] && pipe_err_q[LAST]);
  assign rsp_pop      = rd_rsp_valid && rd_rsp_ready;
  assign fifo_pop     = !fifo_empty && rd_rsp_ready;
  assign fifo_push    = pipe_vld_q[LAST] && !(fifo_empty && rd_rsp_ready);

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_data_q[fifo_wr_ptr_q] <= pipe_data_q[LAST];
      fifo_err_q[fifo_wr_ptr_q]  <= pipe_err_q[LAST];
    end
  end

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    credit_d   = credit_q;
    case ({fifo_push, fifo_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    case ({rd_accept, rsp_pop})
      2'b10:   credit_d = credit_q + CNT_W'(1);
      2'b01:   credit_d = credit_q - CNT_W'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_rd_ptr_q  <= '0;
      fifo_wr_ptr_q  <= '0;
      fifo_cnt_q     <= '0;
      credit_q       <= '0;
      wr_rsp_valid_q <= 1'b0;
      wr_rsp_err_q   <= 1'b0;
      rd_count_q     <= '0;
      wr_count_q     <= '0;
    end else begin
      if (fifo_pop)  fifo_rd_ptr_q <= ptr_inc(fifo_rd_ptr_q);
      if (fifo_push) fifo_wr_ptr_q <= ptr_inc(fifo_wr_ptr_q);
      fifo_cnt_q     <= fifo_cnt_d;
      credit_q       <= credit_d;
      wr_rsp_valid_q <= wr_accept;
      wr_rsp_err_q   <= wr_accept && wr_oor;
      if (rd_accept) rd_count_q <= rd_count_q + 32'd1;
      if (wr_accept) wr_count_q <= wr_count_q + 32'd1;
    end
  end

  // Credits count reads in the pipe plus queued responses, so the queue can never overflow.
  assign rd_req_ready = (credit_q < CNT_W'(RSP_DEPTH));
  assign idle         = (credit_q == '0);
  assign wr_req_ready = 1'b1;
  assign wr_rsp_valid = wr_rsp_valid_q;
  assign wr_rsp_err   = wr_rsp_err_q;
  assign rd_count     = rd_count_q;
  assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_hc_buffer_responder.sv
// Randomized and directed bench for hc_buffer_responder: a memory-array reference model feeds
// an expected-response queue that a negedge monitor pops and compares.
module tb_hc_buffer_responder;
  localparam int NB = 4;
  localparam int MD = 64;
  localparam int DW = 512;
  localparam int OW = 16;
  localparam int RL = 2;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_req_valid, rd_req_ready, rd_rsp_valid, rd_rsp_ready, rd_rsp_err;
  logic [7:0]    rd_req_buffer, wr_req_buffer;
  logic [OW-1:0] rd_req_offset, wr_req_offset;
  logic [DW-1:0] rd_rsp_data, wr_req_data;
  logic          wr_req_valid, wr_req_ready, wr_rsp_valid, wr_rsp_err, idle;
  logic [31:0]   rd_count, wr_count;

  hc_buffer_responder #(
    .NUM_BUFFERS(NB), .MEM_DEPTH(MD), .DATA_WIDTH(DW), .OFFSET_WIDTH(OW),
    .READ_LATENCY(RL), .RSP_DEPTH(RD)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_buffer(rd_req_buffer), .rd_req_offset(rd_req_offset),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
    .rd_rsp_data(rd_rsp_data), .rd_rsp_err(rd_rsp_err),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_buffer(wr_req_buffer), .wr_req_offset(wr_req_offset),
    .wr_req_data(wr_req_data), .wr_rsp_valid(wr_rsp_valid), .wr_rsp_err(wr_rsp_err),
    .idle(idle), .rd_count(rd_count), .wr_count(wr_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] model_mem [NB*MD];
  logic [DW:0]   rd_exp_q [$];
  int            rd_acc_q [$];
  logic          wr_exp_q [$];
  int            wr_acc_q [$];
  logic [31:0]   rd_cnt, wr_cnt;
  int            checks = 0;
  int            errors = 0;
  int            last_lat = 0;

  function automatic logic oor(input logic [7:0] b, input logic [OW-1:0] o);
    return (int'(b) >= NB) || (int'(o) >= MD);
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkw(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic          hold_pend = 1'b0;
  logic [DW:0]   hold_val;

  always @(negedge clk) begin
    if (reset) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) chkw("rsp_stable", {rd_rsp_valid, rd_rsp_err, rd_rsp_data}, {1'b1, hold_val});
      hold_pend = rd_rsp_valid && !rd_rsp_ready;
      hold_val  = {rd_rsp_err, rd_rsp_data};
      if (rd_rsp_valid && rd_rsp_ready) begin
        if (rd_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_rsp_unexpected: got valid response expected none (cycle %0d)", cyc);
        end else begin
          logic [DW:0] e;
          int a;
          e = rd_exp_q.pop_front();
          a = rd_acc_q.pop_front();
          chkw("rd_rsp", {rd_rsp_err, rd_rsp_data}, e);
          last_lat = cyc - a;
          chk1("rd_latency_min", last_lat >= RL, 1'b1);
        end
      end
      if (wr_rsp_valid) begin
        if (wr_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_rsp_unexpected: got pulse expected none (cycle %0d)", cyc);
        end else begin
          logic e;
          int a;
          e = wr_exp_q.pop_front();
          a = wr_acc_q.pop_front();
          chk1("wr_rsp_err", wr_rsp_err, e);
          chk32("wr_rsp_cycle", cyc, a + 1);
        end
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic drive_cycle(input logic rv, input logic [7:0] rb, input logic [OW-1:0] ro,
                             input logic wv, input logic [7:0] wb, input logic [OW-1:0] wo,
                             input logic [DW-1:0] wd, output logic racc);
    chk1("rd_req_ready_credit", rd_req_ready, rd_exp_q.size() < RD);
    chk1("idle_model", idle, rd_exp_q.size() == 0);
    rd_req_valid = rv; rd_req_buffer = rb; rd_req_offset = ro;
    wr_req_valid = wv; wr_req_buffer = wb; wr_req_offset = wo; wr_req_data = wd;
    @(negedge clk);
    racc = rv && rd_req_ready;
    if (racc) begin
      if (oor(rb, ro)) rd_exp_q.push_back({1'b1, {DW{1'b0}}});
      else             rd_exp_q.push_back({1'b0, model_mem[int'(rb) * MD + int'(ro)]});
      rd_acc_q.push_back(cyc);
      rd_cnt++;
    end
    if (wv) begin
      wr_exp_q.push_back(oor(wb, wo));
      wr_acc_q.push_back(cyc);
      wr_cnt++;
      if (!oor(wb, wo)) model_mem[int'(wb) * MD + int'(wo)] = wd;
    end
    @(posedge clk); #1;
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] b, input logic [OW-1:0] o, input logic [DW-1:0] d);
    logic acc;
    drive_cycle(1'b0, 8'd0, '0, 1'b1, b, o, d, acc);
  endtask

  task automatic do_read(input logic [7:0] b, input logic [OW-1:0] o);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      drive_cycle(1'b1, b, o, 1'b0, 8'd0, '0, '0, acc);
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL rd_accept_timeout: got no accept expected accept within 50 cycles");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rd_exp_q.size() != 0 || wr_exp_q.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk1("drain_done", rd_exp_q.size() == 0 && wr_exp_q.size() == 0, 1'b1);
    chk1("idle_after_drain", idle, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic acc;
    int   n_acc;
    reset = 1'b1;
    rd_req_valid = 1'b0; rd_req_buffer = '0; rd_req_offset = '0; rd_rsp_ready = 1'b1;
    wr_req_valid = 1'b0; wr_req_buffer = '0; wr_req_offset = '0; wr_req_data = '0;
    rd_cnt = '0; wr_cnt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_rd_rsp_valid", rd_rsp_valid, 1'b0);
    chk1("rst_wr_rsp_valid", wr_rsp_valid, 1'b0);
    chkw("rst_rd_rsp", {rd_rsp_err, rd_rsp_data}, '0);
    chk1("rst_wr_rsp_err", wr_rsp_err, 1'b0);
    chk1("rst_rd_req_ready", rd_req_ready, 1'b1);
    chk1("rst_idle", idle, 1'b1);
    chk32("rst_rd_count", rd_count, 32'd0);
    chk32("rst_wr_count", wr_count, 32'd0);
    chk1("wr_req_ready", wr_req_ready, 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Preload every word so the model knows the whole storage.
    for (int a = 0; a < NB * MD; a++) do_write(8'(a / MD), OW'(a % MD), rand_word());
    drain();

    // Write then read back with exact latency.
    do_write(8'd1, OW'(5), {(DW/8){8'hA5}});
    do_read(8'd1, OW'(5));
    drain();
    chk32("rd_latency_exact", last_lat, RL);

    // Credit exhaustion with the consumer stalled.
    rd_rsp_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, 8'd2, OW'(i), 1'b0, 8'd0, '0, '0, acc);
      if (acc) n_acc++;
    end
    chk32("credit_accepts", n_acc, 4);
    chk1("credit_ready_low", rd_req_ready, 1'b0);
    rd_rsp_ready = 1'b1;
    do_read(8'd2, OW'(4));
    do_read(8'd2, OW'(5));
    drain();

    // Out-of-range reads and write.
    do_read(8'd4, OW'(0));
    do_read(8'd0, OW'(64));
    do_write(8'd4, OW'(0), {(DW/8){8'h5A}});
    do_read(8'd0, OW'(0));
    drain();

    // Read-first on a same-cycle collision.
    do_write(8'd3, OW'(9), DW'(32'h22));
    drive_cycle(1'b1, 8'd3, OW'(9), 1'b1, 8'd3, OW'(9), DW'(32'h11), acc);
    do_read(8'd3, OW'(9));
    drain();

    // Random traffic, including stalls, collisions and out-of-range requests.
    for (int i = 0; i < 400; i++) begin
      logic [7:0]    rb, wb;
      logic [OW-1:0] ro, wo;
      rd_rsp_ready = ($urandom_range(0, 3) != 0);
      rb = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
      wb = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
      ro = ($urandom_range(0, 9) == 0) ? OW'($urandom_range(64, 65535)) : OW'($urandom_range(0, 7));
      wo = ($urandom_range(0, 9) == 0) ? OW'($urandom_range(64, 65535)) : OW'($urandom_range(0, 7));
      drive_cycle(1'($urandom_range(0, 1)), rb, ro, 1'($urandom_range(0, 1)), wb, wo,
                  rand_word(), acc);
    end
    rd_rsp_ready = 1'b1;
    drain();
    chk32("rd_count_model", rd_count, rd_cnt);
    chk32("wr_count_model", wr_count, wr_cnt);

    // Counter wrap from all-ones.
    force dut.rd_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.rd_count_q;
    rd_cnt = 32'hFFFF_FFFF;
    do_read(8'd7, OW'(0));
    chk32("rd_count_wrap", rd_count, 32'd0);
    chk32("rd_count_wrap_model", rd_count, rd_cnt);
    drain();

    // Reset with three reads in flight.
    rd_rsp_ready = 1'b0;
    do_read(8'd0, OW'(1));
    do_read(8'd0, OW'(2));
    do_read(8'd0, OW'(3));
    chk1("pre_reset_busy", idle, 1'b0);
    reset = 1'b1;
    #2;
    rd_exp_q.delete(); rd_acc_q.delete(); wr_exp_q.delete(); wr_acc_q.delete();
    rd_cnt = '0; wr_cnt = '0;
    chk1("mid_reset_rd_rsp_valid", rd_rsp_valid, 1'b0);
    chk1("mid_reset_idle", idle, 1'b1);
    chk1("mid_reset_ready", rd_req_ready, 1'b1);
    chk32("mid_reset_rd_count", rd_count, 32'd0);
    rd_rsp_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    chk1("post_reset_idle", idle, 1'b1);
    chk1("post_reset_ready", rd_req_ready, 1'b1);
    chk32("post_reset_rd_count", rd_count, 32'd0);
    chk32("post_reset_wr_count", wr_count, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
